// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/enable levels,
// bus widths and the {pc, inst} entry carried from the ROM to IF/ID.
package if_fetch_unit_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic RstDisable  = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
    return a & ~InstAddrBus'(3);
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Small circular queue of fetched {pc, inst} entries. Head/tail pointers wrap
// naturally because DEPTH is a power of two; flush empties it in one edge.
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_entry,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & (count_q != '0);
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy bookkeeping; flush discards every entry.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + AW'(1);
      if (do_pop)  head_q <= head_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // The fetch credit scheme must never push into a full queue.
  always_ff @(posedge clk) begin
    if (rst != RstEnable && !flush) begin
      assert (!(push && full && !do_pop))
        else $error("fetch_fifo: push into a full queue");
    end
  end

  // Entry storage is pure data and is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_entry;
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-cycle-latency ROM reads
// under a credit limit, queues returned words and hands {pc, inst} to IF/ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h00000000,
  parameter int                     DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_ce_o,
  output logic [InstAddrBus-1:0] rom_addr_o,
  input  logic [InstBus-1:0]     rom_data_i,
  output logic                   if_valid_o,
  output logic [InstAddrBus-1:0] if_pc_o,
  output logic [InstBus-1:0]     if_inst_o,
  input  logic                   id_ready_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DepthOcc = (CW+1)'(DEPTH);

  logic [InstAddrBus-1:0] pc_q;
  logic [InstAddrBus-1:0] inflight_pc_q;
  logic                   running_q;
  logic                   inflight_q;
  logic [CW-1:0]          count;
  logic [CW:0]            occ;
  logic                   pop;
  logic                   push;
  logic                   issue;
  fetch_entry_t           head_entry;
  fetch_entry_t           push_entry;

  assign if_valid_o = (count != '0);
  assign if_pc_o    = if_valid_o ? head_entry.pc   : ZeroWord;
  assign if_inst_o  = if_valid_o ? head_entry.inst : ZeroWord;

  // Credits: queued entries plus the returning word, less the one ID takes now.
  assign pop   = if_valid_o & id_ready_i;
  assign occ   = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue = running_q & (occ < DepthOcc) & ~branch_flag_i & (rst != RstEnable);

  assign rom_ce_o   = issue ? ChipEnable : ChipDisable;
  assign rom_addr_o = pc_q;

  // A word returning across a redirect belongs to the old path and is dropped.
  assign push       = inflight_q & ~branch_flag_i;
  assign push_entry = '{pc: inflight_pc_q, inst: rom_data_i};

  // PC, start-up and in-flight control.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc_q       <= RESET_PC;
      running_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      running_q  <= 1'b1;
      inflight_q <= issue;
      if (branch_flag_i) pc_q <= word_align(branch_target_i);
      else if (issue)    pc_q <= pc_q + InstAddrBus'(4);
    end
  end

  // PC of the outstanding read travels with it to pair with the returned word.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc_q <= pc_q;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (branch_flag_i),
    .head_entry (head_entry),
    .count      (count)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random ready/redirect/
// reset traffic, all checked against a program-order model of the fetch stream.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        id_ready_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;

  int vectors = 0;
  int errs    = 0;

  // Model state: the pc ID must receive next, plus bookkeeping for hold/idle rules.
  logic [31:0] exp_pc = RESET_PC;
  int          idle = 0;
  logic        prev_r = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_inst = '0;

  logic        o_valid, o_ce;
  logic [31:0] o_pc, o_inst, o_addr;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_data_i      (rom_data_i),
    .if_valid_o      (if_valid_o),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .id_ready_i      (id_ready_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous ROM with one-cycle read latency.
  always @(posedge clk) begin
    if (rom_ce_o) rom_data_i <= rom_word(rom_addr_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // One clock cycle: drive inputs after the falling edge, observe, apply model rules.
  task automatic tick(input logic r, input logic rdy, input logic br, input logic [31:0] tgt);
    @(negedge clk);
    rst = r; id_ready_i = rdy; branch_flag_i = br; branch_target_i = tgt;
    #1;
    o_valid = if_valid_o; o_ce = rom_ce_o; o_pc = if_pc_o;
    o_inst = if_inst_o; o_addr = rom_addr_o;
    if (prev_r && !r) begin
      chk("post_rst_valid", 32'(o_valid), 32'd0);
      chk("post_rst_ce", 32'(o_ce), 32'd0);
      chk("post_rst_addr", o_addr, RESET_PC);
    end
    if (!r) begin
      if (!o_valid) begin
        chk("idle_pc", o_pc, 32'd0);
        chk("idle_inst", o_inst, 32'd0);
        idle++;
      end else begin
        idle = 0;
      end
      chk("starve", 32'(idle <= 3), 32'd1);
      if (o_ce) chk("addr_align", o_addr & 32'h3, 32'd0);
      if (br) chk("ce_on_branch", 32'(o_ce), 32'd0);
      if (prev_hold) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_pc", o_pc, prev_pc);
        chk("hold_inst", o_inst, prev_inst);
      end
      if (o_valid && rdy) begin
        chk("stream_pc", o_pc, exp_pc);
        chk("stream_inst", o_inst, rom_word(o_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (br) begin
        exp_pc = tgt & ~32'h3;
        idle = 0;
      end
    end else begin
      exp_pc = RESET_PC;
      idle = 0;
    end
    prev_hold = !r && o_valid && !rdy && !br;
    prev_pc   = o_pc;
    prev_inst = o_inst;
    prev_r    = r;
  endtask

  initial begin
    logic        r, rdy, br, last_br;
    logic [31:0] tgt;

    // Reset held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 1'b0, 32'd0);
      if (i > 0) begin
        chk("rst_ce", 32'(o_ce), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_addr", o_addr, RESET_PC);
      end
    end
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_inst", o_inst, 32'd0);

    // Release: first issue one cycle after the first non-reset edge
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("rel_ce_first", 32'(o_ce), 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("rel_ce", 32'(o_ce), 32'd1);
    chk("rel_addr", o_addr, RESET_PC);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("rel_gap", 32'(o_valid), 32'd0);

    // Streaming nine words back to back
    for (int k = 0; k < 9; k++) begin
      tick(1'b0, 1'b1, 1'b0, 32'd0);
      chk("seq_valid", 32'(o_valid), 32'd1);
      chk("seq_pc", o_pc, 32'(4 * k));
    end

    // Return to 0 and stall with pc 0x8 at the head
    tick(1'b0, 1'b1, 1'b1, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("restart_pc", o_pc, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("restart_pc4", o_pc, 32'h4);
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b0, 1'b0, 32'd0);
      chk("stall_pc", o_pc, 32'h8);
      chk("stall_inst", o_inst, rom_word(32'h8));
      chk("stall_ce", 32'(o_ce), 32'd0);
    end
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("unstall_pc8", o_pc, 32'h8);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("unstall_pcC", o_pc, 32'hC);

    // Redirect while 0x10 is popped; target low bits ignored
    tick(1'b0, 1'b1, 1'b1, 32'h00000013);
    chk("redir_pop_pc", o_pc, 32'h10);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("redir_gap1", 32'(o_valid), 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("redir_gap2", 32'(o_valid), 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("redir_valid", 32'(o_valid), 32'd1);
    chk("redir_pc", o_pc, 32'h10);
    chk("redir_inst", o_inst, rom_word(32'h10));

    // PC wrap-around
    tick(1'b0, 1'b1, 1'b1, 32'hFFFFFFF8);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("wrap_pc0", o_pc, 32'hFFFFFFF8);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("wrap_pc1", o_pc, 32'hFFFFFFFC);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("wrap_pc2", o_pc, 32'h00000000);

    // Mid-operation reset with a queued entry and a fetch in flight
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'd0);
    chk("midrst_pc", o_pc, RESET_PC);
    chk("midrst_inst", o_inst, rom_word(RESET_PC));

    // Random traffic against the model
    last_br = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      br  = !r && !last_br && ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                        : 32'($urandom);
      tick(r, rdy, br, tgt);
      last_br = br;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
